mem_arbiter: RTL

Two-port arbiter and sequencer for the shared data-memory port. Accepts requests from the instruction-fetch unit (IFU, port 0) and the load/store unit (LSU, port 1) over valid/ready handshakes. Runs exactly one transaction at a time against the single-cycle DPI-backed memory, with a programmable wait latency, and returns read data or write completion to the granted requester. Sits between the IFU/LSU and the data memory block in the NPC core.

---
 rtl/mem_arb_pkg.sv | 21 ++
 rtl/mem_arb_pick.sv | 34 +++
 rtl/mem_arbiter.sv | 128 ++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_arb_pkg
// Purpose  : Shared types and constants for the data-memory port arbiter.
// Revision : 1.0  initial release
// ============================================================================
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } arb_state_t;

    localparam logic IFU_PORT        = 1'b0;
    localparam logic LSU_PORT        = 1'b1;
    localparam int   DEFAULT_LATENCY = 1;

endpackage
`default_nettype wire

// File: rtl/mem_arb_pick.sv
`default_nettype none
// ============================================================================
// Module   : mem_arb_pick
// Purpose  : Combinational winner selection between IFU and LSU requests.
//            MEM_ARB_RR_EN selects round-robin, otherwise LSU has priority.
// Revision : 1.0  initial release
// ============================================================================
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic [1:0] valid,
`ifdef MEM_ARB_RR_EN
    input  logic       last_grant,
`endif
    output logic       any,
    output logic       grant
);

    always_comb begin
        any = |valid;
`ifdef MEM_ARB_RR_EN
        // On contention the port that did not win last time goes first
        if (&valid) begin
            grant = ~last_grant;
        end else begin
            grant = valid[LSU_PORT] ? LSU_PORT : IFU_PORT;
        end
`else
        grant = valid[LSU_PORT] ? LSU_PORT : IFU_PORT;
`endif
    end

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Purpose  : Two-port arbiter/sequencer for the shared data-memory port, one
//            transaction at a time with programmable wait latency.
//            Optional macro: MEM_ARB_RR_EN (round-robin arbitration).
// Revision : 1.0  initial release
// ============================================================================
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int LATENCY = DEFAULT_LATENCY,
    parameter int CNT_W   = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [1:0][31:0] req_addr,
    input  logic [1:0][31:0] req_wdata,
    input  logic [1:0][2:0]  req_wmask,
    input  logic [1:0]       req_wr,
    output logic [1:0]       resp_valid,
    input  logic [1:0]       resp_ready,
    output logic [1:0][31:0] resp_rdata,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_data,
    output logic [2:0]       mem_wmask,
    output logic             mem_wr,
    output logic             mem_valid,
    input  logic [31:0]      mem_rdata
);

    localparam logic [CNT_W-1:0] c_lat_load = (LATENCY > 0) ? CNT_W'(LATENCY - 1) : '0;

    arb_state_t       r_state;
    arb_state_t       w_next_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_grant;
    logic [31:0]      r_addr;
    logic [31:0]      r_wdata;
    logic [2:0]       r_wmask;
    logic             r_wr;
    logic [31:0]      r_rdata;
    logic             w_any;
    logic             w_pick;
    logic             w_accept;

`ifdef MEM_ARB_RR_EN
    logic             r_last_grant;
`endif

    mem_arb_pick u_pick (
        .valid      (req_valid),
`ifdef MEM_ARB_RR_EN
        .last_grant (r_last_grant),
`endif
        .any        (w_any),
        .grant      (w_pick)
    );

    assign w_accept = (r_state == IDLE) && w_any;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_grant <= IFU_PORT;
            r_addr  <= '0;
            r_wdata <= '0;
            r_wmask <= '0;
            r_wr    <= 1'b0;
            r_rdata <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_accept) begin
                r_grant <= w_pick;
                r_addr  <= req_addr[w_pick];
                r_wdata <= req_wdata[w_pick];
                r_wmask <= req_wmask[w_pick];
                r_wr    <= req_wr[w_pick];
                r_cnt   <= c_lat_load;
            end else if (r_state == WAIT && r_cnt != '0) begin
                r_cnt <= r_cnt - CNT_W'(1);
            end
            // Writes complete with zero data so a stale read value never leaks
            if (r_state == ACCESS) begin
                r_rdata <= r_wr ? 32'h0 : mem_rdata;
            end
        end
    end

`ifdef MEM_ARB_RR_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            r_last_grant <= IFU_PORT;
        end else if (w_accept) begin
            r_last_grant <= w_pick;
        end
    end
`endif

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (w_any) w_next_state = (LATENCY > 0) ? WAIT : ACCESS;
            WAIT:    if (r_cnt == '0) w_next_state = ACCESS;
            ACCESS:  w_next_state = RESP;
            RESP:    if (resp_ready[r_grant]) w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    for (genvar p = 0; p < 2; p++) begin : g_port
        assign req_ready[p]  = w_accept & ~reset & (w_pick == 1'(p));
        assign resp_valid[p] = (r_state == RESP) & (r_grant == 1'(p));
        assign resp_rdata[p] = (r_grant == 1'(p)) ? r_rdata : 32'h0;
    end

    // Strobes are gated by reset so an access in a reset cycle never commits
    assign mem_valid = (r_state == ACCESS) & ~reset;
    assign mem_wr    = mem_valid & r_wr;
    assign mem_addr  = r_addr;
    assign mem_data  = r_wdata;
    assign mem_wmask = r_wmask;

endmodule
`default_nettype wire
